// File: rtl/control_types_pkg.sv
// Shared pipeline-control types used by the forwarding and hazard units.
package control_types_pkg;

  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_EX_MEM,
    FWD_MEM_WB
  } forwarding_src_t;

  typedef enum logic {
    ST_RUN,
    ST_MDU_WAIT
  } hazard_state_t;

endpackage

// File: rtl/load_use_detector.sv
// Flags an ID instruction that needs the result of a load still sitting in EX.
module load_use_detector (
  input  logic [4:0] id_reg1_idx,
  input  logic [4:0] id_reg2_idx,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_reg_wr_idx,
  input  logic       ex_reg_wr_en,
  input  logic       ex_mem_rd,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_reg1_idx == ex_reg_wr_idx);
  assign rs2_hit = id_uses_rs2 && (id_reg2_idx == ex_reg_wr_idx);

  // x0 is never a real dependency, so a load targeting it cannot cause a stall.
  assign load_use = ex_mem_rd && ex_reg_wr_en && (ex_reg_wr_idx != 5'd0) &&
                    (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline with MDU watchdog and stall counter.
module hazard_control_unit
  import control_types_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_reg1_idx,
  input  logic [4:0]             id_reg2_idx,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [4:0]             ex_reg_wr_idx,
  input  logic                   ex_reg_wr_en,
  input  logic                   ex_mem_rd,
  input  logic                   ex_mdu_start,
  input  logic                   mdu_done,
  input  logic                   ex_redirect,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   if_id_flush,
  output logic                   id_ex_stall,
  output logic                   id_ex_flush,
  output logic                   ex_mem_stall,
  output logic                   ex_mem_flush,
  output logic                   mem_wb_flush,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   mdu_timeout
);

  localparam int WD_W = $clog2(MDU_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MDU_TIMEOUT);

  hazard_state_t   state;
  logic [WD_W-1:0] wd_cnt;
  logic            mem_wait;
  logic            mdu_busy;
  logic            load_use;

  assign mem_wait = mem_req && !mem_ready;
  assign mdu_busy = ex_mdu_start && !mdu_done;

  load_use_detector u_load_use_detector (
    .id_reg1_idx   (id_reg1_idx),
    .id_reg2_idx   (id_reg2_idx),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .ex_reg_wr_idx (ex_reg_wr_idx),
    .ex_reg_wr_en  (ex_reg_wr_en),
    .ex_mem_rd     (ex_mem_rd),
    .load_use      (load_use)
  );

  // A redirect beats load_use because the dependent ID instruction is wrong-path anyway.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_wait) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mdu_busy) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_flush  = 1'b1;
    end
  end

  // The watchdog only runs while parked in ST_MDU_WAIT; the timeout flag is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      wd_cnt      <= '0;
      mdu_timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          wd_cnt <= '0;
          if (mdu_busy && !mem_wait) state <= ST_MDU_WAIT;
        end
        ST_MDU_WAIT: begin
          if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
          if (wd_cnt >= WD_MAX - 1'b1) mdu_timeout <= 1'b1;
          if (mdu_done && !mem_wait) begin
            state  <= ST_RUN;
            wd_cnt <= '0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (pc_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

  a_mem_req_stable: assert property (@(posedge clk) disable iff (rst)
    mem_wait |=> mem_req);

  a_mdu_start_held: assert property (@(posedge clk) disable iff (rst)
    (state == ST_MDU_WAIT) |-> ex_mdu_start);

  a_no_stall_flush: assert property (@(posedge clk) disable iff (rst)
    !((if_id_stall && if_id_flush) || (id_ex_stall && id_ex_flush) ||
      (ex_mem_stall && ex_mem_flush)));

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with a rule-level reference model.
module tb_hazard_control_unit;

  localparam int MDU_TO  = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  localparam logic [7:0] V_NONE = 8'h00;
  localparam logic [7:0] V_LU   = 8'hC8;
  localparam logic [7:0] V_MW   = 8'hD5;
  localparam logic [7:0] V_MB   = 8'hD2;
  localparam logic [7:0] V_RD   = 8'h28;
  localparam logic [7:0] V_RST  = 8'h2B;

  typedef struct packed {
    logic       rst;
    logic [4:0] r1;
    logic       u1;
    logic [4:0] r2;
    logic       u2;
    logic [4:0] wi;
    logic       we;
    logic       mrd;
    logic       ms;
    logic       md;
    logic       rd;
    logic       mq;
    logic       mr;
  } stim_t;

  logic clk;
  logic rst;
  logic [4:0] id_reg1_idx, id_reg2_idx, ex_reg_wr_idx;
  logic id_uses_rs1, id_uses_rs2, ex_reg_wr_en, ex_mem_rd;
  logic ex_mdu_start, mdu_done, ex_redirect, mem_req, mem_ready;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, ex_mem_flush, mem_wb_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic mdu_timeout;

  int total = 0;
  int bad   = 0;

  bit         lit_en = 1'b0;
  string      lit_name = "";
  logic [7:0] lit_out = '0;
  int         lit_cnt = 0;
  int         lit_to  = 0;

  int         m_cycles = 0;
  bit         m_in_wait = 1'b0;
  int         m_wait = 0;
  bit         m_to = 1'b0;
  logic [7:0] exp_v;
  logic [7:0] out_v;
  bit         mw, mb, lu;

  hazard_control_unit #(.MDU_TIMEOUT(MDU_TO), .STALL_CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_reg1_idx   (id_reg1_idx),
    .id_reg2_idx   (id_reg2_idx),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .ex_reg_wr_idx (ex_reg_wr_idx),
    .ex_reg_wr_en  (ex_reg_wr_en),
    .ex_mem_rd     (ex_mem_rd),
    .ex_mdu_start  (ex_mdu_start),
    .mdu_done      (mdu_done),
    .ex_redirect   (ex_redirect),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .pc_stall      (pc_stall),
    .if_id_stall   (if_id_stall),
    .if_id_flush   (if_id_flush),
    .id_ex_stall   (id_ex_stall),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_stall  (ex_mem_stall),
    .ex_mem_flush  (ex_mem_flush),
    .mem_wb_flush  (mem_wb_flush),
    .stall_cycles  (stall_cycles),
    .mdu_timeout   (mdu_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t vec(input logic rst_v, input logic [4:0] r1, input logic u1,
                                input logic [4:0] r2, input logic u2, input logic [4:0] wi,
                                input logic we, input logic mrd, input logic ms,
                                input logic md, input logic rdir, input logic mq,
                                input logic mr);
    stim_t s;
    s.rst = rst_v; s.r1 = r1; s.u1 = u1; s.r2 = r2; s.u2 = u2; s.wi = wi;
    s.we = we; s.mrd = mrd; s.ms = ms; s.md = md; s.rd = rdir; s.mq = mq; s.mr = mr;
    return s;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input stim_t s, input string name, input logic [7:0] e_out,
                               input int e_cnt, input int e_to);
    @(posedge clk);
    #1;
    rst = s.rst; id_reg1_idx = s.r1; id_uses_rs1 = s.u1; id_reg2_idx = s.r2;
    id_uses_rs2 = s.u2; ex_reg_wr_idx = s.wi; ex_reg_wr_en = s.we; ex_mem_rd = s.mrd;
    ex_mdu_start = s.ms; mdu_done = s.md; ex_redirect = s.rd; mem_req = s.mq;
    mem_ready = s.mr;
    lit_name = name; lit_out = e_out; lit_cnt = e_cnt; lit_to = e_to; lit_en = 1'b1;
  endtask

  // Reference model: priority rules evaluated on the live inputs, then state advanced.
  always @(negedge clk) begin
    out_v = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
             ex_mem_stall, ex_mem_flush, mem_wb_flush};
    mw = mem_req && !mem_ready;
    mb = ex_mdu_start && !mdu_done;
    lu = ex_mem_rd && ex_reg_wr_en && (ex_reg_wr_idx != 0) &&
         ((id_uses_rs1 && id_reg1_idx == ex_reg_wr_idx) ||
          (id_uses_rs2 && id_reg2_idx == ex_reg_wr_idx));
    if (rst) begin
      m_cycles = 0; m_in_wait = 1'b0; m_wait = 0; m_to = 1'b0;
      exp_v = V_RST;
    end else if (mw)          exp_v = V_MW;
    else if (mb)              exp_v = V_MB;
    else if (ex_redirect)     exp_v = V_RD;
    else if (lu)              exp_v = V_LU;
    else                      exp_v = V_NONE;

    checkOutput("ctrl", int'(out_v), int'(exp_v));
    checkOutput("stall_cycles", int'(stall_cycles), m_cycles);
    checkOutput("mdu_timeout", int'(mdu_timeout), int'(m_to));
    if (lit_en) begin
      checkOutput({lit_name, "/ctrl"}, int'(out_v), int'(lit_out));
      checkOutput({lit_name, "/cnt"}, int'(stall_cycles), lit_cnt);
      checkOutput({lit_name, "/timeout"}, int'(mdu_timeout), lit_to);
    end

    if (!rst) begin
      if (exp_v[7] && m_cycles < CNT_MAX) m_cycles++;
      if (m_in_wait) begin
        m_wait++;
        if (m_wait >= MDU_TO) m_to = 1'b1;
        if (mdu_done && !mw) begin
          m_in_wait = 1'b0;
          m_wait = 0;
        end
      end else if (mb && !mw) begin
        m_in_wait = 1'b1;
      end
    end
  end

  initial begin
    rst = 1'b1; id_reg1_idx = '0; id_reg2_idx = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_reg_wr_idx = '0; ex_reg_wr_en = 0; ex_mem_rd = 0; ex_mdu_start = 0; mdu_done = 0;
    ex_redirect = 0; mem_req = 0; mem_ready = 0;

    applyStimulus(vec(1, 0,0, 0,0, 0,0,0, 0,0, 0, 0,0), "reset_idle",   V_RST, 0, 0);
    applyStimulus(vec(1, 5,1, 0,0, 5,1,1, 1,0, 1, 0,0), "reset_forces", V_RST, 0, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 0,0, 0, 0,0), "idle",         V_NONE, 0, 0);
    applyStimulus(vec(0, 5,1, 0,0, 5,1,1, 0,0, 0, 0,0), "lu_rs1",       V_LU,  0, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 0,0, 0, 0,0), "lu_release",   V_NONE, 1, 0);
    applyStimulus(vec(0, 0,1, 0,0, 0,1,1, 0,0, 0, 0,0), "lu_x0",        V_NONE, 1, 0);
    applyStimulus(vec(0, 5,0, 5,0, 5,1,1, 0,0, 0, 0,0), "lu_unused",    V_NONE, 1, 0);
    applyStimulus(vec(0, 0,0, 7,1, 7,1,1, 0,0, 0, 0,0), "lu_rs2",       V_LU,  1, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 0,0, 0, 0,0), "idle2",        V_NONE, 2, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 1,0, 0, 0,0), "mdu_w1",       V_MB,  2, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 1,0, 0, 0,0), "mdu_w2",       V_MB,  3, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 1,0, 0, 0,0), "mdu_w3",       V_MB,  4, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 1,1, 0, 0,0), "mdu_done",     V_NONE, 5, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 0,0, 0, 0,0), "idle3",        V_NONE, 5, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 1,1, 0, 0,0), "mdu_single",   V_NONE, 5, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 0,0, 0, 0,0), "idle4",        V_NONE, 5, 0);
    applyStimulus(vec(0, 5,1, 0,0, 5,1,1, 0,0, 1, 1,0), "memw1",        V_MW,  5, 0);
    applyStimulus(vec(0, 5,1, 0,0, 5,1,1, 0,0, 1, 1,0), "memw2",        V_MW,  6, 0);
    applyStimulus(vec(0, 5,1, 0,0, 5,1,1, 0,0, 1, 1,1), "redir_after",  V_RD,  7, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 0,0, 0, 0,0), "idle5",        V_NONE, 7, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 1,0, 0, 0,0), "wd_enter",     V_MB,  7, 0);
    for (int i = 0; i < 7; i++)
      applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 1,0, 0, 0,0), "wd_wait",    V_MB,  8 + i, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 1,0, 0, 0,0), "wd_last",      V_MB,  15, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 1,0, 0, 0,0), "wd_timeout",   V_MB,  15, 1);
    for (int i = 0; i < 5; i++)
      applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 1,0, 0, 0,0), "wd_sticky",  V_MB,  15, 1);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 1,0, 0, 1,0), "wd_memw",      V_MW,  15, 1);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 1,1, 0, 1,1), "wd_release",   V_NONE, 15, 1);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 1,0, 0, 0,0), "rst_pre",      V_MB,  15, 1);
    applyStimulus(vec(1, 0,0, 0,0, 0,0,0, 1,0, 0, 0,0), "rst_mid",      V_RST, 0, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 0,0, 0, 0,0), "post_rst",     V_NONE, 0, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 0,0, 1, 0,0), "redirect",     V_RD,  0, 0);
    applyStimulus(vec(0, 0,0, 0,0, 0,0,0, 0,0, 0, 0,0), "final_idle",   V_NONE, 0, 0);

    @(negedge clk);
    #2;
    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). It detects load-use hazards, which the forwarding unit cannot cover. It holds the pipeline during multi-cycle MDU (mul/div) operations and data-memory wait states, and flushes wrong-path instructions on taken branches and jumps. It drives the enable/clear controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It keeps a saturating stall-cycle counter and an MDU watchdog.

Parameters:
MDU_TIMEOUT, 64, cycles in MDU_WAIT before mdu_timeout sets (>=2)
STALL_CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
id_reg1_idx  in  5  rs1 of instruction in ID
id_reg2_idx  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_reg_wr_idx  in  5  rd of instruction in EX
ex_reg_wr_en  in  1  EX instruction writes rd
ex_mem_rd  in  1  EX instruction is a load
ex_mdu_start  in  1  EX holds an MDU op (level, held while EX frozen)
mdu_done  in  1  MDU result valid this cycle
ex_redirect  in  1  EX branch taken / jump resolved
mem_req  in  1  MEM stage accessing data memory
mem_ready  in  1  data memory completes access this cycle
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  clear IF/ID to NOP
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  clear ID/EX to bubble
ex_mem_stall  out  1  hold EX/MEM
ex_mem_flush  out  1  insert bubble into EX/MEM
mem_wb_flush  out  1  insert bubble into MEM/WB
stall_cycles  out  STALL_CNT_W  cycles with pc_stall=1, saturating
mdu_timeout  out  1  sticky watchdog error

Behaviour:
- While rst=1: state=ST_RUN, stall_cycles=0, mdu_timeout=0, watchdog=0, all *_flush=1, all *_stall=0.
- Stall/flush outputs are combinational from the current state and inputs, and act in the same cycle. State, watchdog and counters are registered.
- Hazard terms:
  - mem_wait = mem_req & !mem_ready
  - mdu_busy = ex_mdu_start & !mdu_done
  - load_use = ex_mem_rd & ex_reg_wr_en & ex_reg_wr_idx!=0 & ((id_uses_rs1 & id_reg1_idx==ex_reg_wr_idx) | (id_uses_rs2 & id_reg2_idx==ex_reg_wr_idx))
- Priority, highest first; exactly one action per cycle:
  1. mem_wait: pc, if_id, id_ex, ex_mem stall; mem_wb_flush=1; all other flushes 0.
  2. mdu_busy: pc, if_id, id_ex stall; ex_mem_flush=1.
  3. ex_redirect: if_id_flush=1 and id_ex_flush=1; no stalls. Redirect overrides a simultaneous load_use because the ID instruction is wrong-path.
  4. load_use: pc and if_id stall; id_ex_flush=1 (exactly one bubble, since the next cycle the load is in MEM and forwarding covers it).
  5. Otherwise all outputs 0.
- ex_redirect is ignored while mem_wait or mdu_busy. EX holds the branch, so the redirect is re-presented once the stall releases.
- FSM, 2 states:
  - ST_RUN -> ST_MDU_WAIT when mdu_busy & !mem_wait.
  - ST_MDU_WAIT -> ST_RUN on mdu_done.
  - mem_wait in ST_MDU_WAIT keeps the state.
  - A single-cycle MDU (mdu_done coincident with ex_mdu_start) never leaves ST_RUN and causes no stall.
- Watchdog:
  - Counts cycles in ST_MDU_WAIT; resets on entering ST_RUN.
  - When it reaches MDU_TIMEOUT, mdu_timeout sets and stays set until rst. The FSM is unaffected.
  - The watchdog saturates.
- stall_cycles increments on every cycle with pc_stall=1 and saturates at all-ones (no wrap).
- Reset mid-stall: returns to ST_RUN immediately (asynchronous); counters clear.
- Assertions:
  - mem_req stays stable while mem_wait.
  - ex_mdu_start stays high while in ST_MDU_WAIT until mdu_done.
  - No *_stall and *_flush asserted together for the same register.

Decomposition:
- Add hazard_state_t (ST_RUN, ST_MDU_WAIT) to the shared control_types package, alongside forwarding_src_t.
- One combinational sub-module, load_use_detector, computes load_use so it can be unit-tested with the forwarding unit bench style.
- Priority mux, FSM, watchdog and counter stay in the top.

Test Plan:
- Load x5 in EX (ex_mem_rd=1, wr_en=1, idx=5), ID add with rs1=5 -> one cycle pc_stall=if_id_stall=id_ex_flush=1, next cycle all 0; stall_cycles=1.
- Same load but rd=x0, or ID rs1=5 with id_uses_rs1=0 -> no stall.
- ex_mdu_start=1, mdu_done on 4th cycle -> 3 cycles pc/if_id/id_ex stall with ex_mem_flush, state ST_MDU_WAIT, release on done cycle; single-cycle done -> no stall.
- mem_req=1, mem_ready=0 for 2 cycles while load_use and ex_redirect also asserted -> 2 cycles full freeze + mem_wb_flush, then redirect flush, load_use bubble suppressed.
- MDU_TIMEOUT=8, mdu_done never -> mdu_timeout rises after 8 wait cycles and stays; rst clears it and forces all flushes during reset.
- Force stall_cycles near max (STALL_CNT_W=4, 20 stall cycles) -> saturates at 15.
